fetch_stage: RTL and testbench

Fetch stage and IF/ID pipeline register of the pipelined ARM core, directly upstream of the decode/controller pipeline. Holds the program counter, drives the instruction-memory address, and captures the fetched instruction into the Decode-stage register that feeds `Instr[31:12]` to the controller. Applies stall, flush and PC-redirect requests from the hazard unit and the Execute/Writeback stages.

---
 rtl/arm_pipe_pkg.sv | 24 ++
 rtl/flopenrc.sv | 32 +++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared constants and types for the ARM pipeline front end
//
// Purpose : datapath width, reset defaults and the packed IF/ID register layout
//           used by the fetch stage.
// Ports   : none (package)

package arm_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Instructions are one word; the PC always advances by this amount.
    localparam logic [XLEN-1:0] PC_INCR = 32'd4;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcPlus4;
        logic            valid;
    } decode_reg_t;

endpackage

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - parameterised flop with enable and synchronous clear
//
// Purpose : generic pipeline register. reset and clear both load RESET_VAL;
//           otherwise the register loads d when en is high and holds when low.
// Ports   : clk   - clock, rising edge
//           reset - synchronous active-high reset
//           en    - load enable
//           clear - synchronous clear (same value as reset, beats en)
//           d     - next value
//           q     - registered value

module flopenrc #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch stage and IF/ID register of the pipelined ARM core
//
// Purpose : holds the PC, drives the instruction-memory address and captures
//           the fetched word into the Decode-stage register.
// Ports   : clk, reset          - clock and synchronous active-high reset
//           StallF, StallD     - hold PC / hold Decode register
//           FlushD             - load a bubble into Decode (beats StallD)
//           BranchTakenE       - redirect to ALUResultE
//           PCSrcW             - redirect to ResultW (beats BranchTakenE)
//           PCF                - instruction-memory address
//           InstrF             - instruction-memory read data
//           InstrD, PCPlus4D   - registered instruction and its PC+4
//           PCPlus8D           - PCPlus4D + 4 (R15 read value)
//           ValidD             - InstrD is a real instruction, not a bubble

module fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    localparam decode_reg_t DECODE_BUBBLE = '{
        instr:   NOP_INSTR,
        pcPlus4: '0,
        valid:   1'b0
    };

    logic [XLEN-1:0] pcPlus4F;
    logic [XLEN-1:0] pcNextF;
    logic            redirectF;
    logic            pcEn;
    decode_reg_t     decodeNext;
    decode_reg_t     decodeQ;

    assign pcPlus4F  = PCF + PC_INCR;
    assign redirectF = PCSrcW | BranchTakenE;

    // A Writeback write to R15 is older than a branch in Execute, so it wins.
    always_comb begin
        pcNextF = pcPlus4F;
        if (PCSrcW) begin
            pcNextF = ResultW;
        end else if (BranchTakenE) begin
            pcNextF = ALUResultE;
        end
    end

    // Redirects must never be lost to a fetch stall.
    assign pcEn = ~StallF | redirectF;

    flopenrc #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pcReg (
        .clk   (clk),
        .reset (reset),
        .en    (pcEn),
        .clear (1'b0),
        .d     (pcNextF),
        .q     (PCF)
    );

    assign decodeNext = '{
        instr:   InstrF,
        pcPlus4: pcPlus4F,
        valid:   1'b1
    };

    flopenrc #(
        .WIDTH     ($bits(decode_reg_t)),
        .RESET_VAL (DECODE_BUBBLE)
    ) u_decodeReg (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clear (FlushD),
        .d     (decodeNext),
        .q     (decodeQ)
    );

    assign InstrD   = decodeQ.instr;
    assign PCPlus4D = decodeQ.pcPlus4;
    assign ValidD   = decodeQ.valid;
    assign PCPlus8D = decodeQ.pcPlus4 + PC_INCR;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic [31:0] PCF, InstrF, InstrD, PCPlus4D, PCPlus8D;
    logic        ValidD;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .PCF          (PCF),
        .InstrF       (InstrF),
        .InstrD       (InstrD),
        .PCPlus4D     (PCPlus4D),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word i holds E2800000 + i.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'hE280_0000 + {2'b00, addr[31:2]};
    endfunction

    assign InstrF = memWord(PCF);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic [31:0] p8;
        logic        v;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Architectural reference state.
    logic [31:0] mPc, mInstr, mP4;
    logic        mV;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("PCF",      PCF,              e.pc);
            check("InstrD",   InstrD,           e.instr);
            check("PCPlus4D", PCPlus4D,         e.p4);
            check("PCPlus8D", PCPlus8D,         e.p8);
            check("ValidD",   {31'b0, ValidD},  {31'b0, e.v});
        end
    end

    // Drive one cycle's inputs, advance the model, and queue the expected state.
    task automatic step(input logic rst, input logic sF, input logic sD, input logic fD,
                        input logic br, input logic [31:0] alu,
                        input logic pw, input logic [31:0] res);
        logic [31:0] fetched;
        exp_t e;
        @(negedge clk);
        reset = rst; StallF = sF; StallD = sD; FlushD = fD;
        BranchTakenE = br; ALUResultE = alu; PCSrcW = pw; ResultW = res;
        if (rst) begin
            mPc = RST_PC; mInstr = NOP; mP4 = 32'h0; mV = 1'b0;
        end else begin
            fetched = memWord(mPc);
            if (fD) begin
                mInstr = NOP; mP4 = 32'h0; mV = 1'b0;
            end else if (!sD) begin
                mInstr = fetched; mP4 = mPc + 32'd4; mV = 1'b1;
            end
            if (pw)       mPc = res;
            else if (br)  mPc = alu;
            else if (!sF) mPc = mPc + 32'd4;
        end
        e.pc = mPc; e.instr = mInstr; e.p4 = mP4; e.p8 = mP4 + 32'd4; e.v = mV;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; StallF = 0; StallD = 0; FlushD = 0;
        BranchTakenE = 0; ALUResultE = 0; PCSrcW = 0; ResultW = 0;
        mPc = RST_PC; mInstr = NOP; mP4 = 0; mV = 0;

        step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        step(1, 1, 1, 0, 1, 32'h40, 1, 32'h80);   // reset beats everything
        idle(2);                                  // PCF 4, 8
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);     // stall at PCF=8
        step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        idle(3);
        step(0, 0, 0, 1, 1, 32'h100, 0, 32'h0);   // branch + flush
        idle(2);
        step(0, 1, 0, 0, 1, 32'h100, 1, 32'h200); // PCSrcW beats branch and stall
        idle(1);
        step(0, 0, 1, 1, 0, 32'h0, 0, 32'h0);     // flush beats stall
        step(1, 1, 1, 0, 0, 32'h0, 0, 32'h0);     // reset while stalled
        idle(2);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        idle(3);                                  // wrap to 0
        step(0, 0, 0, 0, 1, 32'h0000_0123, 0, 32'h0); // unaligned target passes through
        idle(1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 11) == 0), $urandom);
        end
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
